// File: rtl/rfphoenix_alu_seq.sv
// rfphoenix_alu_seq: parametrised integer ALU for the execute stage. Single-cycle
// ops are registered directly; MUL (2-stage product) and DIV (restoring) iterate.
module rfphoenix_alu_seq #(
  parameter int WID  = 32,
  parameter int TAGW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [4:0]      op,
  input  logic [WID-1:0]  a,
  input  logic [WID-1:0]  b,
  input  logic [TAGW-1:0] tag,
  output logic            out_vld,
  output logic [TAGW-1:0] out_tag,
  output logic [WID-1:0]  o,
  output logic            dbz
);
  localparam int SHW = $clog2(WID);
  localparam int NW  = $clog2(WID + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_LT  = 5'd8,  OP_LTU = 5'd9,  OP_EQ  = 5'd10, OP_CLZ = 5'd11;
  localparam logic [4:0] OP_POP = 5'd12, OP_MUL = 5'd13, OP_MULH = 5'd14, OP_MULHU = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16, OP_DIVU = 5'd17, OP_REM = 5'd18, OP_REMU = 5'd19;

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic [WID-1:0]   opa_q, opa_d;   // MUL operand a, or DIV dividend/quotient shift register
  logic [WID-1:0]   opb_q, opb_d;   // MUL operand b, or DIV divisor magnitude
  logic [WID-1:0]   rem_q, rem_d;
  logic [2*WID-1:0] prod_q, prod_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             out_vld_q, out_vld_d, dbz_q, dbz_d;
  logic [TAGW-1:0]  out_tag_q, out_tag_d;
  logic [WID-1:0]   o_q, o_d;

  logic [SHW-1:0]   shamt;
  logic [NW-1:0]    lz, pop;
  logic [WID-1:0]   alu_res;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    shamt = b[SHW-1:0];
    lz    = NW'(WID);
    pop   = '0;
    for (int i = 0; i < WID; i++) begin
      if (a[i]) lz = NW'(WID - 1 - i);
      pop = pop + NW'(a[i]);
    end
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = $signed(a) >>> shamt;
      OP_LT:  alu_res = {{(WID-1){1'b0}}, $signed(a) < $signed(b)};
      OP_LTU: alu_res = {{(WID-1){1'b0}}, a < b};
      OP_EQ:  alu_res = {{(WID-1){1'b0}}, a == b};
      OP_CLZ: alu_res = WID'(lz);
      OP_POP: alu_res = WID'(pop);
      default: alu_res = '0;
    endcase
  end

  // Operands extended to 2*WID so one multiplier serves signed and unsigned high halves.
  logic             mul_sx;
  logic [2*WID-1:0] mul_xa, mul_xb, mul_prod;
  logic [WID:0]     div_shift;
  logic             div_ge;
  logic [WID-1:0]   div_rem, div_quo, quo_fix, rem_fix, fin_res;

  always_comb begin
    mul_sx    = (op_q == OP_MULH);
    mul_xa    = {{WID{mul_sx & opa_q[WID-1]}}, opa_q};
    mul_xb    = {{WID{mul_sx & opb_q[WID-1]}}, opb_q};
    mul_prod  = mul_xa * mul_xb;

    div_shift = {rem_q, opa_q[WID-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem   = div_ge ? (div_shift[WID-1:0] - opb_q) : div_shift[WID-1:0];
    div_quo   = {opa_q[WID-2:0], div_ge};

    // The last quotient bit is resolved here, in FIN, alongside the sign fixup.
    quo_fix = qneg_q ? -div_quo : div_quo;
    rem_fix = rneg_q ? -div_rem : div_rem;
    fin_res = prod_q[WID-1:0];
    case (op_q)
      OP_MULH, OP_MULHU: fin_res = prod_q[2*WID-1:WID];
      OP_DIV, OP_DIVU:   fin_res = dz_q ? '1 : quo_fix;
      OP_REM, OP_REMU:   fin_res = rem_fix;
      default:           fin_res = prod_q[WID-1:0];
    endcase
  end

  logic a_neg, b_neg;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    prod_d    = prod_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    out_vld_d = 1'b0;
    out_tag_d = out_tag_q;
    o_d       = o_q;
    dbz_d     = 1'b0;
    a_neg     = ((op == OP_DIV) || (op == OP_REM)) && a[WID-1];
    b_neg     = ((op == OP_DIV) || (op == OP_REM)) && b[WID-1];
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          op_d  = op;
          tag_d = tag;
          if (op >= OP_MUL && op <= OP_MULHU) begin
            opa_d   = a;
            opb_d   = b;
            dz_d    = 1'b0;
            cnt_d   = SHW'(1);
            state_d = S_MUL;
          end else if (op >= OP_DIV && op <= OP_REMU) begin
            opa_d   = a_neg ? -a : a;
            opb_d   = b_neg ? -b : b;
            rem_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (b == '0);
            cnt_d   = SHW'(WID - 1);
            state_d = S_DIV;
          end else begin
            out_vld_d = 1'b1;
            out_tag_d = tag;
            o_d       = alu_res;
          end
        end
      end
      S_MUL: begin
        prod_d = mul_prod;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_d == '0) state_d = S_FIN;
      end
      S_DIV: begin
        opa_d = div_quo;
        rem_d = div_rem;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_d == '0) state_d = S_FIN;
      end
      default: begin
        out_vld_d = 1'b1;
        out_tag_d = tag_q;
        o_d       = fin_res;
        dbz_d     = dz_q;
        state_d   = S_IDLE;
      end
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      out_vld_d = 1'b0;
      out_tag_d = out_tag_q;
      o_d       = o_q;
      dbz_d     = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // flops sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_tag_q <= '0;
      o_q       <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      out_tag_q <= out_tag_d;
      o_q       <= o_d;
      dbz_q     <= dbz_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept
  // before the FSM ever reads them, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    tag_q  <= tag_d;
    opa_q  <= opa_d;
    opb_q  <= opb_d;
    rem_q  <= rem_d;
    prod_q <= prod_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dz_q   <= dz_d;
  end

  assign in_rdy  = (state_q == S_IDLE);
  assign out_vld = out_vld_q;
  assign out_tag = out_tag_q;
  assign o       = o_q;
  assign dbz     = dbz_q;
endmodule

// File: tb/tb_rfphoenix_alu_seq.sv
// Directed testbench for rfphoenix_alu_seq: a WID=32 instance for most scenarios
// and a WID=64 instance for the wide divide regression.
module tb_rfphoenix_alu_seq;
  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  ANDo = 5'd2,  ORo = 5'd3,  XORo = 5'd4;
  localparam logic [4:0] SLL = 5'd5,  SRL = 5'd6,  SRA = 5'd7,   LT = 5'd8,   LTU = 5'd9;
  localparam logic [4:0] EQ = 5'd10,  CLZ = 5'd11, POP = 5'd12,  MUL = 5'd13, MULH = 5'd14;
  localparam logic [4:0] MULHU = 5'd15, DIV = 5'd16, DIVU = 5'd17, REM = 5'd18, REMU = 5'd19;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        abort = 1'b0;

  logic        i32_vld = 1'b0;
  logic [4:0]  i32_op = '0;
  logic [31:0] i32_a = '0, i32_b = '0;
  logic [5:0]  i32_tag = '0;
  logic        o32_rdy, o32_vld, o32_dbz;
  logic [5:0]  o32_tag;
  logic [31:0] o32_o;

  logic        i64_vld = 1'b0;
  logic [4:0]  i64_op = '0;
  logic [63:0] i64_a = '0, i64_b = '0;
  logic [5:0]  i64_tag = '0;
  logic        o64_rdy, o64_vld, o64_dbz;
  logic [5:0]  o64_tag;
  logic [63:0] o64_o;

  int checks = 0;
  int failures = 0;
  vec_t tbl [0:16];

  always #5 clk = ~clk;

  rfphoenix_alu_seq #(.WID(32), .TAGW(6)) u32 (
    .clk(clk), .rst(rst), .abort(abort), .in_vld(i32_vld), .in_rdy(o32_rdy),
    .op(i32_op), .a(i32_a), .b(i32_b), .tag(i32_tag), .out_vld(o32_vld),
    .out_tag(o32_tag), .o(o32_o), .dbz(o32_dbz)
  );

  rfphoenix_alu_seq #(.WID(64), .TAGW(6)) u64 (
    .clk(clk), .rst(rst), .abort(abort), .in_vld(i64_vld), .in_rdy(o64_rdy),
    .op(i64_op), .a(i64_a), .b(i64_b), .tag(i64_tag), .out_vld(o64_vld),
    .out_tag(o64_tag), .o(o64_o), .dbz(o64_dbz)
  );

  task automatic drive32(input logic [4:0] f_op, input logic [31:0] fa, input logic [31:0] fb,
                         input logic [5:0] ftag);
    i32_vld = 1'b1;
    i32_op  = f_op;
    i32_a   = fa;
    i32_b   = fb;
    i32_tag = ftag;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o32_vld, o32_dbz, o32_rdy} !== 3'b001 || o32_o !== 32'h0 || o32_tag !== 6'h0) begin
      failures++;
      $display("FAIL reset32: vld=%b dbz=%b rdy=%b o=%h tag=%h, want 0 0 1 0 0",
               o32_vld, o32_dbz, o32_rdy, o32_o, o32_tag);
    end
    checks++;
    if ({o64_vld, o64_dbz, o64_rdy} !== 3'b001 || o64_o !== 64'h0 || o64_tag !== 6'h0) begin
      failures++;
      $display("FAIL reset64: vld=%b dbz=%b rdy=%b o=%h tag=%h, want 0 0 1 0 0",
               o64_vld, o64_dbz, o64_rdy, o64_o, o64_tag);
    end
    rst = 1'b0;
  endtask

  task automatic test_simple;
    logic [31:0] exp_o [3];
    logic [4:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    exp_o = '{32'h0, 32'hF800_0000, 32'd15};
    ops   = '{ADD, SRA, CLZ};
    as    = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    bs    = '{32'd1, 32'd4, 32'd0};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive32(ops[i], as[i], bs[i], 6'(i + 1));
      @(negedge clk);
      checks++;
      if (o32_vld !== 1'b1 || o32_o !== exp_o[i] || o32_tag !== 6'(i + 1)) begin
        failures++;
        $display("FAIL simple[%0d]: vld=%b o=%h tag=%0d, want 1 %h %0d",
                 i, o32_vld, o32_o, o32_tag, exp_o[i], i + 1);
      end
    end
    i32_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (o32_vld !== 1'b0 || o32_o !== 32'd15) begin
      failures++;
      $display("FAIL simple_hold: vld=%b o=%h, want 0 0000000f", o32_vld, o32_o);
    end
  endtask

  task automatic test_single_table;
    tbl[0]  = '{SUB,  32'd3,          32'd5,          32'hFFFF_FFFE};
    tbl[1]  = '{ANDo, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'h00F0_F000};
    tbl[2]  = '{ORo,  32'h00FF_0000,  32'h0000_000F,  32'h00FF_000F};
    tbl[3]  = '{XORo, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
    tbl[4]  = '{SLL,  32'd1,          32'd31,         32'h8000_0000};
    tbl[5]  = '{SLL,  32'd1,          32'd33,         32'h0000_0002};
    tbl[6]  = '{SRL,  32'h8000_0000,  32'd31,         32'h0000_0001};
    tbl[7]  = '{SRA,  32'h7FFF_FFF0,  32'd4,          32'h07FF_FFFF};
    tbl[8]  = '{LT,   32'hFFFF_FFFF,  32'd0,          32'd1};
    tbl[9]  = '{LTU,  32'hFFFF_FFFF,  32'd0,          32'd0};
    tbl[10] = '{EQ,   32'h0000_1234,  32'h0000_1234,  32'd1};
    tbl[11] = '{CLZ,  32'h0,          32'd0,          32'd32};
    tbl[12] = '{CLZ,  32'hFFFF_FFFF,  32'd0,          32'd0};
    tbl[13] = '{POP,  32'hF0F0_0001,  32'd0,          32'd9};
    tbl[14] = '{POP,  32'hFFFF_FFFF,  32'd0,          32'd32};
    tbl[15] = '{5'd25, 32'd5,         32'd6,          32'd0};
    tbl[16] = '{ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000};
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      drive32(tbl[i].op, tbl[i].a, tbl[i].b, 6'(i + 32));
      @(negedge clk);
      checks++;
      if (o32_vld !== 1'b1 || o32_o !== tbl[i].e || o32_tag !== 6'(i + 32)) begin
        failures++;
        $display("FAIL table[%0d] op=%0d: vld=%b o=%h tag=%0d, want 1 %h %0d",
                 i, tbl[i].op, o32_vld, o32_o, o32_tag, tbl[i].e, i + 32);
      end
    end
    i32_vld = 1'b0;
  endtask

  // Issues one op on the selected instance and measures latency and in_rdy-low cycles.
  task automatic run_op(input bit w64, input logic [4:0] f_op, input logic [63:0] fa,
                        input logic [63:0] fb, input logic [5:0] ftag, input logic [63:0] exp_o,
                        input logic exp_dbz, input int exp_lat, input string name);
    int lat;
    int low;
    logic vld, rdy, dz;
    logic [63:0] obs;
    logic [5:0] otag;
    @(negedge clk);
    if (w64) begin
      i64_vld = 1'b1; i64_op = f_op; i64_a = fa; i64_b = fb; i64_tag = ftag;
    end else begin
      drive32(f_op, fa[31:0], fb[31:0], ftag);
    end
    @(negedge clk);
    i32_vld = 1'b0;
    i64_vld = 1'b0;
    lat = 1;
    low = 0;
    vld = w64 ? o64_vld : o32_vld;
    while (vld !== 1'b1 && lat < 200) begin
      rdy = w64 ? o64_rdy : o32_rdy;
      if (rdy !== 1'b1) low++;
      @(negedge clk);
      lat++;
      vld = w64 ? o64_vld : o32_vld;
    end
    rdy  = w64 ? o64_rdy : o32_rdy;
    dz   = w64 ? o64_dbz : o32_dbz;
    obs  = w64 ? o64_o : {32'h0, o32_o};
    otag = w64 ? o64_tag : o32_tag;
    checks++;
    if (vld !== 1'b1 || lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d edges (vld=%b), want %0d", name, lat, vld, exp_lat);
    end
    checks++;
    if (obs !== exp_o || otag !== ftag || dz !== exp_dbz) begin
      failures++;
      $display("FAIL %s result: o=%h tag=%0d dbz=%b, want o=%h tag=%0d dbz=%b",
               name, obs, otag, dz, exp_o, ftag, exp_dbz);
    end
    checks++;
    if (low != exp_lat - 1 || rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s in_rdy: low %0d cycles, rdy at strobe=%b, want %0d and 1",
               name, low, rdy, exp_lat - 1);
    end
  endtask

  task automatic test_multiply;
    run_op(1'b0, MULH,  64'hFFFF_FFFE, 64'd3, 6'd5, 64'hFFFF_FFFF, 1'b0, 3, "mulh");
    run_op(1'b0, MULHU, 64'hFFFF_FFFE, 64'd3, 6'd6, 64'h2,         1'b0, 3, "mulhu");
    run_op(1'b0, MUL,   64'hFFFF_FFFE, 64'd3, 6'd7, 64'hFFFF_FFFA, 1'b0, 3, "mul");
  endtask

  task automatic test_divide;
    run_op(1'b0, DIV,  64'hFFFF_FFF9, 64'd2, 6'd8,  64'hFFFF_FFFD, 1'b0, 33, "div");
    run_op(1'b0, REM,  64'hFFFF_FFF9, 64'd2, 6'd9,  64'hFFFF_FFFF, 1'b0, 33, "rem");
    run_op(1'b0, DIVU, 64'd100,       64'd7, 6'd10, 64'd14,        1'b0, 33, "divu");
  endtask

  task automatic test_edge_cases;
    run_op(1'b0, DIVU, 64'd5, 64'd0, 6'd14, 64'hFFFF_FFFF, 1'b1, 33, "divu_by0");
    run_op(1'b0, REMU, 64'd5, 64'd0, 6'd15, 64'd5,         1'b1, 33, "remu_by0");
    run_op(1'b0, DIV,  64'h8000_0000, 64'hFFFF_FFFF, 6'd16, 64'h8000_0000, 1'b0, 33, "div_ovf");
    run_op(1'b0, REM,  64'h8000_0000, 64'hFFFF_FFFF, 6'd17, 64'h0,         1'b0, 33, "rem_ovf");
  endtask

  // An ADD accepted in the same cycle as the MUL strobe returns one cycle later.
  task automatic test_back_to_back;
    int bud;
    @(negedge clk);
    drive32(MUL, 32'd6, 32'd7, 6'd18);
    @(negedge clk);
    i32_vld = 1'b0;
    bud = 0;
    while (o32_vld !== 1'b1 && bud < 10) begin
      @(negedge clk);
      bud++;
    end
    checks++;
    if (o32_vld !== 1'b1 || o32_o !== 32'd42 || o32_rdy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_mul: vld=%b o=%h rdy=%b, want 1 0000002a 1", o32_vld, o32_o, o32_rdy);
    end
    drive32(ADD, 32'd10, 32'd20, 6'd19);
    @(negedge clk);
    i32_vld = 1'b0;
    checks++;
    if (o32_vld !== 1'b1 || o32_o !== 32'd30 || o32_tag !== 6'd19) begin
      failures++;
      $display("FAIL b2b_add: vld=%b o=%h tag=%0d, want 1 0000001e 19", o32_vld, o32_o, o32_tag);
    end
  endtask

  task automatic test_abort;
    logic stale;
    @(negedge clk);
    drive32(DIV, 32'd100, 32'd7, 6'd20);
    @(negedge clk);
    i32_vld = 1'b0;
    stale = 1'b0;
    repeat (8) begin
      if (o32_vld !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (o32_rdy !== 1'b1 || o32_vld !== 1'b0 || stale) begin
      failures++;
      $display("FAIL abort_div: rdy=%b vld=%b stale=%b, want 1 0 0", o32_rdy, o32_vld, stale);
    end
    drive32(ADD, 32'd2, 32'd3, 6'd21);
    @(negedge clk);
    checks++;
    if (o32_vld !== 1'b1 || o32_o !== 32'd5 || o32_tag !== 6'd21) begin
      failures++;
      $display("FAIL abort_add: vld=%b o=%h tag=%0d, want 1 00000005 21", o32_vld, o32_o, o32_tag);
    end
    drive32(ADD, 32'd7, 32'd8, 6'd22);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    i32_vld = 1'b0;
    checks++;
    if (o32_vld !== 1'b1 || o32_o !== 32'd15 || o32_tag !== 6'd22) begin
      failures++;
      $display("FAIL abort_idle: vld=%b o=%h tag=%0d, want 1 0000000f 22", o32_vld, o32_o, o32_tag);
    end
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o32_vld !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL abort_stale: out_vld seen after abort, want none");
    end
  endtask

  task automatic test_reset_mid_mul;
    logic stale;
    @(negedge clk);
    drive32(MUL, 32'd6, 32'd7, 6'd23);
    @(negedge clk);
    i32_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({o32_vld, o32_dbz, o32_rdy} !== 3'b001 || o32_o !== 32'h0 || o32_tag !== 6'h0) begin
      failures++;
      $display("FAIL rst_mul: vld=%b dbz=%b rdy=%b o=%h tag=%h, want 0 0 1 0 0",
               o32_vld, o32_dbz, o32_rdy, o32_o, o32_tag);
    end
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o32_vld !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale || o32_o !== 32'h0) begin
      failures++;
      $display("FAIL rst_stale: stale=%b o=%h, want 0 00000000", stale, o32_o);
    end
  endtask

  task automatic test_wid64;
    run_op(1'b1, DIVU, 64'h8000_0000_0000_0000, 64'd3, 6'd24,
           64'h2AAA_AAAA_AAAA_AAAA, 1'b0, 65, "divu64");
    run_op(1'b1, DIV, 64'hFFFF_FFFF_FFFF_FFF7, 64'd4, 6'd25,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65, "div64");
    run_op(1'b1, MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd26, 64'd1, 1'b0, 3, "mulhu64");
  endtask

  initial begin
    test_reset();
    test_simple();
    test_single_table();
    test_multiply();
    test_divide();
    test_edge_cases();
    test_back_to_back();
    test_abort();
    test_reset_mid_mul();
    test_wid64();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
